// File: rtl/grf_wport_arbiter.sv
// grf_wport_arbiter: arbitrates the single GRF write port between the W stage (A) and the MDU (B)
// Ports:
//   clk, reset                  clock and asynchronous active-high reset
//   a_req/a_wa/a_wd/a_pc, a_gnt pipeline writeback request and combinational grant
//   b_req/b_wa/b_wd/b_pc, b_gnt MDU writeback request and combinational grant
//   b_starve                    B holds forced priority this cycle
//   grf_we/grf_wa/grf_wd/grf_pc registered write issued to the GRF
module grf_wport_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic [4:0]  a_wa,
    input  logic [31:0] a_wd,
    input  logic [31:0] a_pc,
    output logic        a_gnt,
    input  logic        b_req,
    input  logic [4:0]  b_wa,
    input  logic [31:0] b_wd,
    input  logic [31:0] b_pc,
    output logic        b_gnt,
    output logic        b_starve,
    output logic        grf_we,
    output logic [4:0]  grf_wa,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);
    logic [3:0]  wcnt_q, wcnt_d;
    logic        we_q, we_d;
    logic [4:0]  wa_q, wa_d;
    logic [31:0] wd_q, wd_d, pc_q, pc_d;
    logic        any_gnt;
    // wcnt >= MAX_WAIT written as wcnt + 1 > MAX_WAIT so MAX_WAIT = 0 does not fold to a constant compare
    assign b_starve = ~reset & b_req & (({1'b0, wcnt_q} + 5'd1) > 5'(MAX_WAIT));
    assign b_gnt    = ~reset & b_req & (~a_req | b_starve);
    assign a_gnt    = ~reset & a_req & ~b_starve;
    assign any_gnt  = a_gnt | b_gnt;
    always_comb begin
        wcnt_d = (b_gnt | ~b_req) ? 4'd0 : ((wcnt_q == 4'd15) ? 4'd15 : wcnt_q + 4'd1);
        wa_d   = a_gnt ? a_wa : (b_gnt ? b_wa : wa_q);
        wd_d   = a_gnt ? a_wd : (b_gnt ? b_wd : wd_q);
        pc_d   = a_gnt ? a_pc : (b_gnt ? b_pc : pc_q);
        we_d   = any_gnt & (wa_d != 5'd0);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q <= 4'd0;
            we_q   <= 1'b0;
            wa_q   <= 5'd0;
            wd_q   <= 32'd0;
            pc_q   <= 32'd0;
        end else begin
            wcnt_q <= wcnt_d;
            we_q   <= we_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            pc_q   <= pc_d;
        end
    end
    assign grf_we = we_q;
    assign grf_wa = wa_q;
    assign grf_wd = wd_q;
    assign grf_pc = pc_q;
endmodule

// File: tb/tb_grf_wport_arbiter.sv
// tb_grf_wport_arbiter: directed table-driven check of grf_wport_arbiter (MAX_WAIT=4 and MAX_WAIT=0)
module tb_grf_wport_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0, b_req = 1'b0;
    logic [4:0]  a_wa = '0, b_wa = '0;
    logic [31:0] a_wd = '0, a_pc = '0, b_wd = '0, b_pc = '0;
    logic        a_gnt, b_gnt, b_starve, grf_we;
    logic [4:0]  grf_wa;
    logic [31:0] grf_wd, grf_pc;
    logic        a_gnt0, b_gnt0, b_starve0, grf_we0;
    logic [4:0]  grf_wa0;
    logic [31:0] grf_wd0, grf_pc0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    grf_wport_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_wa(a_wa), .a_wd(a_wd), .a_pc(a_pc), .a_gnt(a_gnt),
        .b_req(b_req), .b_wa(b_wa), .b_wd(b_wd), .b_pc(b_pc), .b_gnt(b_gnt),
        .b_starve(b_starve),
        .grf_we(grf_we), .grf_wa(grf_wa), .grf_wd(grf_wd), .grf_pc(grf_pc)
    );

    grf_wport_arbiter #(.MAX_WAIT(0)) dut0 (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_wa(a_wa), .a_wd(a_wd), .a_pc(a_pc), .a_gnt(a_gnt0),
        .b_req(b_req), .b_wa(b_wa), .b_wd(b_wd), .b_pc(b_pc), .b_gnt(b_gnt0),
        .b_starve(b_starve0),
        .grf_we(grf_we0), .grf_wa(grf_wa0), .grf_wd(grf_wd0), .grf_pc(grf_pc0)
    );

    typedef struct {
        logic        ar;
        logic [4:0]  aw;
        logic [31:0] ad, ap;
        logic        br;
        logic [4:0]  bw;
        logic [31:0] bd, bp;
        logic        ga, gb, st, we;
        logic [4:0]  wa;
        logic [31:0] wd, pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic ar, input logic [4:0] aw, input logic [31:0] ad, input logic [31:0] ap,
                               input logic br, input logic [4:0] bw, input logic [31:0] bd, input logic [31:0] bp,
                               input logic ga, input logic gb, input logic st, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
        vec_t r;
        r.ar = ar; r.aw = aw; r.ad = ad; r.ap = ap;
        r.br = br; r.bw = bw; r.bd = bd; r.bp = bp;
        r.ga = ga; r.gb = gb; r.st = st; r.we = we;
        r.wa = wa; r.wd = wd; r.pc = pc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ar, input logic [4:0] aw, input logic [31:0] ad, input logic [31:0] ap,
                         input logic br, input logic [4:0] bw, input logic [31:0] bd, input logic [31:0] bp);
        a_req = ar; a_wa = aw; a_wd = ad; a_pc = ap;
        b_req = br; b_wa = bw; b_wd = bd; b_pc = bp;
    endtask

    task automatic chk_out0(input string tag, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
        chk({tag, " grf_we"}, 32'(grf_we), 32'(wa != 5'd0));
        chk({tag, " grf_wa"}, 32'(grf_wa), 32'(wa));
        chk({tag, " grf_wd"}, grf_wd, wd);
        chk({tag, " grf_pc"}, grf_pc, pc);
    endtask

    initial begin
        // Rows: inputs for one cycle, grants expected within it, GRF outputs expected after its closing edge
        tbl.push_back(v(1,  5, 32'h1234, 32'h3000, 0,  0, 0, 0,                 1,0,0, 1,  5, 32'h1234, 32'h3000));
        tbl.push_back(v(0,  5, 32'h1234, 32'h3000, 0,  0, 0, 0,                 0,0,0, 0,  5, 32'h1234, 32'h3000));
        tbl.push_back(v(1,  1, 32'h11,   32'h1004, 0,  0, 0, 0,                 1,0,0, 1,  1, 32'h11,   32'h1004));
        tbl.push_back(v(1,  2, 32'h22,   32'h1008, 0,  0, 0, 0,                 1,0,0, 1,  2, 32'h22,   32'h1008));
        tbl.push_back(v(1,  3, 32'h33,   32'h100C, 0,  0, 0, 0,                 1,0,0, 1,  3, 32'h33,   32'h100C));
        tbl.push_back(v(0,  0, 0,        0,        1,  0, 32'hFFFFFFFF, 32'h200, 0,1,0, 0,  0, 32'hFFFFFFFF, 32'h200));
        tbl.push_back(v(1,  6, 32'hA6,   32'h1018, 1,  9, 32'hB0B0, 32'h400,    1,0,0, 1,  6, 32'hA6,   32'h1018));
        tbl.push_back(v(1,  7, 32'hA7,   32'h101C, 1,  9, 32'hB0B0, 32'h400,    1,0,0, 1,  7, 32'hA7,   32'h101C));
        tbl.push_back(v(1,  8, 32'hA8,   32'h1020, 1,  9, 32'hB0B0, 32'h400,    1,0,0, 1,  8, 32'hA8,   32'h1020));
        tbl.push_back(v(1, 10, 32'hAA,   32'h1028, 1,  9, 32'hB0B0, 32'h400,    1,0,0, 1, 10, 32'hAA,   32'h1028));
        tbl.push_back(v(1, 12, 32'hAC,   32'h1030, 1,  9, 32'hB0B0, 32'h400,    0,1,1, 1,  9, 32'hB0B0, 32'h400));
        tbl.push_back(v(1, 12, 32'hAC,   32'h1030, 1, 17, 32'hB1,   32'h404,    1,0,0, 1, 12, 32'hAC,   32'h1030));
        tbl.push_back(v(1, 13, 32'hAD,   32'h1034, 1, 17, 32'hB1,   32'h404,    1,0,0, 1, 13, 32'hAD,   32'h1034));
        tbl.push_back(v(1, 14, 32'hAE,   32'h1038, 1, 17, 32'hB1,   32'h404,    1,0,0, 1, 14, 32'hAE,   32'h1038));
        tbl.push_back(v(1, 15, 32'hAF,   32'h103C, 1, 17, 32'hB1,   32'h404,    1,0,0, 1, 15, 32'hAF,   32'h103C));
        tbl.push_back(v(1, 16, 32'hB0,   32'h1040, 1, 17, 32'hB1,   32'h404,    0,1,1, 1, 17, 32'hB1,   32'h404));
        tbl.push_back(v(0,  0, 0,        0,        0,  0, 0, 0,                 0,0,0, 0, 17, 32'hB1,   32'h404));
        tbl.push_back(v(1, 20, 32'hB4,   32'h1050, 1, 25, 32'hC5,   32'h500,    1,0,0, 1, 20, 32'hB4,   32'h1050));
        tbl.push_back(v(1, 21, 32'hB5,   32'h1054, 1, 25, 32'hC5,   32'h500,    1,0,0, 1, 21, 32'hB5,   32'h1054));
        tbl.push_back(v(1, 22, 32'hB6,   32'h1058, 1, 25, 32'hC5,   32'h500,    1,0,0, 1, 22, 32'hB6,   32'h1058));
        tbl.push_back(v(1, 23, 32'hB7,   32'h105C, 1, 25, 32'hC5,   32'h500,    1,0,0, 1, 23, 32'hB7,   32'h105C));
        tbl.push_back(v(1, 24, 32'hB8,   32'h1060, 0, 25, 32'hC5,   32'h500,    1,0,0, 1, 24, 32'hB8,   32'h1060));
        tbl.push_back(v(1, 26, 32'hBA,   32'h1068, 1, 25, 32'hC5,   32'h500,    1,0,0, 1, 26, 32'hBA,   32'h1068));
        tbl.push_back(v(0,  0, 0,        0,        1, 25, 32'hC5,   32'h500,    0,1,0, 1, 25, 32'hC5,   32'h500));

        // Reset values, with requests present to prove grants are gated by reset
        drive(1, 3, 32'h3, 32'h3, 1, 4, 32'h4, 32'h4);
        #2;
        chk("rst a_gnt", 32'(a_gnt), 0);
        chk("rst b_gnt", 32'(b_gnt), 0);
        chk("rst b_starve", 32'(b_starve), 0);
        chk_out0("rst", 5'd0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk_out0("idle after rst", 5'd0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].ar, tbl[i].aw, tbl[i].ad, tbl[i].ap, tbl[i].br, tbl[i].bw, tbl[i].bd, tbl[i].bp);
            #1;
            chk($sformatf("v%0d a_gnt", i), 32'(a_gnt), 32'(tbl[i].ga));
            chk($sformatf("v%0d b_gnt", i), 32'(b_gnt), 32'(tbl[i].gb));
            chk($sformatf("v%0d b_starve", i), 32'(b_starve), 32'(tbl[i].st));
            @(posedge clk); #1;
            chk($sformatf("v%0d grf_we", i), 32'(grf_we), 32'(tbl[i].we));
            chk($sformatf("v%0d grf_wa", i), 32'(grf_wa), 32'(tbl[i].wa));
            chk($sformatf("v%0d grf_wd", i), grf_wd, tbl[i].wd);
            chk($sformatf("v%0d grf_pc", i), grf_pc, tbl[i].pc);
        end

        // Asynchronous reset mid-cycle while a write is issuing and another is accepted
        drive(1, 4, 32'h44, 32'h2000, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_out0("pre-rst issue", 5'd4, 32'h44, 32'h2000);
        drive(1, 5, 32'h55, 32'h2004, 1, 6, 32'h66, 32'h2008);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst a_gnt", 32'(a_gnt), 0);
        chk("midrst b_gnt", 32'(b_gnt), 0);
        chk("midrst b_starve", 32'(b_starve), 0);
        chk_out0("midrst", 5'd0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk_out0("post-rst 1", 5'd0, 0, 0);
        @(posedge clk); #1;
        chk_out0("post-rst 2", 5'd0, 0, 0);

        // MAX_WAIT=0 instance: B wins every contended cycle until it releases
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 32'h101, 32'h3100, 1, 2, 32'h200 + 32'(k), 32'h3200 + 32'(4 * k));
            #1;
            chk($sformatf("mw0 c%0d a_gnt", k), 32'(a_gnt0), 0);
            chk($sformatf("mw0 c%0d b_gnt", k), 32'(b_gnt0), 1);
            chk($sformatf("mw0 c%0d b_starve", k), 32'(b_starve0), 1);
            @(posedge clk); #1;
            chk($sformatf("mw0 c%0d grf_we", k), 32'(grf_we0), 1);
            chk($sformatf("mw0 c%0d grf_wa", k), 32'(grf_wa0), 2);
            chk($sformatf("mw0 c%0d grf_wd", k), grf_wd0, 32'h200 + 32'(k));
        end
        drive(1, 1, 32'h101, 32'h3100, 0, 0, 0, 0);
        #1;
        chk("mw0 rel a_gnt", 32'(a_gnt0), 1);
        chk("mw0 rel b_gnt", 32'(b_gnt0), 0);
        @(posedge clk); #1;
        chk("mw0 rel grf_wa", 32'(grf_wa0), 1);
        chk("mw0 rel grf_wd", grf_wd0, 32'h101);
        chk("mw0 rel grf_pc", grf_pc0, 32'h3100);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
